// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the forwarding/hazard controller: select encodings,
// scoreboard geometry and the per-stage producer record.
package fwd_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    SEL_GPR  = 2'b00,
    SEL_MEM1 = 2'b01,
    SEL_MEM2 = 2'b10,
    SEL_WB   = 2'b11
  } fwd_sel_e;

  localparam int unsigned STAGES  = 3;
  localparam int unsigned ST_EX   = 0;
  localparam int unsigned ST_MEM1 = 1;
  localparam int unsigned ST_MEM2 = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       wr;
    logic       load;
  } sb_entry_t;

  // Register 0 is hard-wired, so it never has a producer.
  function automatic logic sb_match(sb_entry_t e, logic [4:0] r);
    return e.valid && e.wr && (e.dst == r) && (r != 5'd0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side bundle of the forwarding/hazard controller: ID-stage operand
// description and freeze/flush controls in, forwarding selects and stalls out.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import fwd_hazard_ctrl_pkg::*;

  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_rs_ex;
  logic             id_rt_ex;
  logic             id_rs_br;
  logic             id_rt_br;
  logic [4:0]       id_dst;
  logic             id_wr;
  logic             id_load;
  logic             hold;
  logic             flush;

  fwd_sel_e         MUX4Sel;
  fwd_sel_e         MUX5Sel;
  fwd_sel_e         MUX8Sel;
  fwd_sel_e         MUX9Sel;
  logic             stall_id;
  logic             bubble_ex;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_ex, id_rt_ex, id_rs_br, id_rt_br,
           id_dst, id_wr, id_load, hold, flush,
    input  MUX4Sel, MUX5Sel, MUX8Sel, MUX9Sel, stall_id, bubble_ex, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_ex, id_rt_ex, id_rs_br, id_rt_br,
           id_dst, id_wr, id_load, hold, flush,
    output MUX4Sel, MUX5Sel, MUX8Sel, MUX9Sel, stall_id, bubble_ex, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_ctrl_operand_cmp.sv
// Resolves one ID source operand against the EX/MEM1/MEM2 scoreboard:
// nearest producer wins, giving EX and ID-compare selects plus a hazard flag.
module fwd_operand_cmp
  import fwd_hazard_ctrl_pkg::*;
(
  input  sb_entry_t [STAGES-1:0] sb_i,
  input  logic [4:0]             src_i,
  input  logic                   use_ex_i,
  input  logic                   use_br_i,
  output fwd_sel_e               ex_sel_o,
  output fwd_sel_e               id_sel_o,
  output logic                   hazard_o
);

  logic [STAGES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      hit[i] = sb_match(sb_i[i], src_i);
    end
  end

  // The if/else-if chain encodes priority: younger producers shadow older ones.
  always_comb begin
    ex_sel_o = SEL_GPR;
    id_sel_o = SEL_GPR;
    hazard_o = 1'b0;
    if (hit[ST_EX]) begin
      if (use_ex_i) begin
        ex_sel_o = SEL_MEM1;
      end
      hazard_o = (use_ex_i && sb_i[ST_EX].load) || use_br_i;
    end else if (hit[ST_MEM1]) begin
      if (use_ex_i) begin
        ex_sel_o = SEL_MEM2;
      end
      if (use_br_i && !sb_i[ST_MEM1].load) begin
        id_sel_o = SEL_MEM2;
      end
      hazard_o = sb_i[ST_MEM1].load && (use_ex_i || use_br_i);
    end else if (hit[ST_MEM2]) begin
      if (use_ex_i) begin
        ex_sel_o = SEL_WB;
      end
      if (use_br_i && !sb_i[ST_MEM2].load) begin
        id_sel_o = SEL_WB;
      end
      hazard_o = use_br_i && sb_i[ST_MEM2].load;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard-stall controller: tracks in-flight producers, drives
// EX/ID forwarding selects, ID stall / EX bubble and a saturating stall counter.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  fwd_hazard_ctrl_if.slave bus
);

  sb_entry_t [STAGES-1:0] sb_q, sb_d;
  fwd_sel_e               mux4_q, mux4_d;
  fwd_sel_e               mux5_q, mux5_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  fwd_sel_e rs_ex_sel, rs_id_sel, rt_ex_sel, rt_id_sel;
  logic     rs_haz, rt_haz;
  logic     haz_stall, accept;

  fwd_operand_cmp u_rs_cmp (
    .sb_i     (sb_q),
    .src_i    (bus.id_rs),
    .use_ex_i (bus.id_rs_ex),
    .use_br_i (bus.id_rs_br),
    .ex_sel_o (rs_ex_sel),
    .id_sel_o (rs_id_sel),
    .hazard_o (rs_haz)
  );

  fwd_operand_cmp u_rt_cmp (
    .sb_i     (sb_q),
    .src_i    (bus.id_rt),
    .use_ex_i (bus.id_rt_ex),
    .use_br_i (bus.id_rt_br),
    .ex_sel_o (rt_ex_sel),
    .id_sel_o (rt_id_sel),
    .hazard_o (rt_haz)
  );

  always_comb begin
    haz_stall = (rs_haz || rt_haz) && bus.id_valid && !bus.flush;
    accept    = bus.id_valid && !haz_stall && !bus.flush;
  end

  // Under hold everything keeps its value, so flush and hazards have no effect on state.
  always_comb begin
    sb_d   = sb_q;
    mux4_d = mux4_q;
    mux5_d = mux5_q;
    cnt_d  = cnt_q;
    if (!bus.hold) begin
      sb_d[ST_MEM2]       = sb_q[ST_MEM1];
      sb_d[ST_MEM1]       = sb_q[ST_EX];
      sb_d[ST_EX].valid   = accept;
      sb_d[ST_EX].dst     = bus.id_dst;
      sb_d[ST_EX].wr      = bus.id_wr;
      sb_d[ST_EX].load    = bus.id_load;
      mux4_d = accept ? rs_ex_sel : SEL_GPR;
      mux5_d = accept ? rt_ex_sel : SEL_GPR;
      if (haz_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q   <= '0;
      mux4_q <= SEL_GPR;
      mux5_q <= SEL_GPR;
      cnt_q  <= '0;
    end else begin
      sb_q   <= sb_d;
      mux4_q <= mux4_d;
      mux5_q <= mux5_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.MUX4Sel   = mux4_q;
  assign bus.MUX5Sel   = mux5_q;
  assign bus.MUX8Sel   = rs_id_sel;
  assign bus.MUX9Sel   = rt_id_sel;
  assign bus.stall_id  = haz_stall || bus.hold;
  assign bus.bubble_ex = haz_stall && !bus.hold;
  assign bus.stall_cnt = cnt_q;

endmodule
